// File: rtl/crc5_pkg.sv
// Shared CRC-5 (EPC Gen2, x^5+x^3+1) definitions for the transmit generator and the checker.
package crc5_pkg;

    localparam int unsigned     CRC5_W      = 5;
    localparam logic [CRC5_W-1:0] CRC5_PRESET = 5'b01001;
    localparam logic [CRC5_W-1:0] CRC5_POLY   = 5'b01001;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_DATA,
        SHIFT_CRC,
        DONE
    } crc5_state_e;

    // One serial step: feedback taps land on x^3 and x^0.
    function automatic logic [CRC5_W-1:0] crc5_step(input logic [CRC5_W-1:0] r, input logic d);
        logic fb;
        fb = d ^ r[CRC5_W-1];
        return {r[CRC5_W-2:0], 1'b0} ^ ({CRC5_W{fb}} & CRC5_POLY);
    endfunction

endpackage

// File: rtl/crc5_tx_gen_if.sv
// Handshake/bus bundle between a frame source and crc5_tx_gen.
// Optional err_inject signal present only when CRC5_ERR_INJECT_EN is defined.
interface crc5_tx_gen_if #(
    parameter int PAYLOAD_W = 17
);
    logic                 load;
    logic [PAYLOAD_W-1:0] payload;
    logic                 bit_en;
`ifdef CRC5_ERR_INJECT_EN
    logic                 err_inject;
`endif
    logic                 tx_data;
    logic                 tx_valid;
    logic                 busy;
    logic                 done;
    logic [4:0]           crc5_out;

    modport master (
        output load, payload, bit_en,
`ifdef CRC5_ERR_INJECT_EN
        output err_inject,
`endif
        input  tx_data, tx_valid, busy, done, crc5_out
    );

    modport slave (
        input  load, payload, bit_en,
`ifdef CRC5_ERR_INJECT_EN
        input  err_inject,
`endif
        output tx_data, tx_valid, busy, done, crc5_out
    );

endinterface

// File: rtl/crc5_lfsr.sv
// CRC-5 register with preset, serial data step and zero-fill shift-out; reusable by the checker.
module crc5_lfsr
    import crc5_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_preset,
    input  logic              i_step,
    input  logic              i_shift_out,
    input  logic              i_d,
    output logic [CRC5_W-1:0] o_crc
);

    logic [CRC5_W-1:0] r_crc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_crc <= CRC5_PRESET;
        end else if (i_preset) begin
            r_crc <= CRC5_PRESET;
        end else if (i_step) begin
            r_crc <= crc5_step(r_crc, i_d);
        end else if (i_shift_out) begin
            r_crc <= {r_crc[CRC5_W-2:0], 1'b0};
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/crc5_tx_gen.sv
// Serial EPC Gen2 frame transmitter: payload MSB first, then its CRC-5 MSB first.
// Define CRC5_ERR_INJECT_EN to add err_inject (inverts the last CRC bit on the wire).
module crc5_tx_gen
    import crc5_pkg::*;
#(
    parameter int PAYLOAD_W = 17
) (
    input  logic           clk_crc5,
    input  logic           rst_for_new_package,
    crc5_tx_gen_if.slave   bus
);

    localparam int unsigned CNT_W = 6;

    crc5_state_e          r_state;
    logic [PAYLOAD_W-1:0] r_shift;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_tx_data;
    logic                 r_tx_valid;
    logic                 r_busy;
    logic                 r_done;
    logic [CRC5_W-1:0]    r_crc_hold;
    logic [CRC5_W-1:0]    r_crc5_out;

    logic [PAYLOAD_W-1:0] w_shift_nxt;
    logic [CRC5_W-1:0]    w_crc;
    logic [CRC5_W-1:0]    w_crc_stepped;
    logic                 w_preset;
    logic                 w_step;
    logic                 w_shift_out;
    logic                 w_d;
    logic                 w_err;

    assign w_d           = r_shift[PAYLOAD_W-1];
    assign w_preset      = (r_state == IDLE) && bus.load;
    assign w_step        = (r_state == SHIFT_DATA) && bus.bit_en;
    assign w_shift_out   = (r_state == SHIFT_CRC) && bus.bit_en;
    assign w_shift_nxt   = r_shift << 1;
    assign w_crc_stepped = crc5_step(w_crc, w_d);

    crc5_lfsr u_lfsr (
        .i_clk       (clk_crc5),
        .i_rst_n     (rst_for_new_package),
        .i_preset    (w_preset),
        .i_step      (w_step),
        .i_shift_out (w_shift_out),
        .i_d         (w_d),
        .o_crc       (w_crc)
    );

`ifdef CRC5_ERR_INJECT_EN
    logic r_err;

    always_ff @(posedge clk_crc5 or negedge rst_for_new_package) begin
        if (!rst_for_new_package) begin
            r_err <= 1'b0;
        end else if (w_preset) begin
            r_err <= bus.err_inject;
        end
    end

    assign w_err = r_err;
`else
    assign w_err = 1'b0;
`endif

    // tx_data is registered, so each branch loads the bit that will be on the wire next cycle.
    always_ff @(posedge clk_crc5 or negedge rst_for_new_package) begin
        if (!rst_for_new_package) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_tx_data  <= 1'b0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_crc_hold <= '0;
            r_crc5_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.load) begin
                        r_state    <= SHIFT_DATA;
                        r_shift    <= bus.payload;
                        r_cnt      <= CNT_W'(PAYLOAD_W - 1);
                        r_tx_data  <= bus.payload[PAYLOAD_W-1];
                        r_tx_valid <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                SHIFT_DATA: begin
                    if (bus.bit_en) begin
                        r_shift <= w_shift_nxt;
                        if (r_cnt == '0) begin
                            r_state    <= SHIFT_CRC;
                            r_cnt      <= CNT_W'(CRC5_W - 1);
                            r_crc_hold <= w_crc_stepped;
                            r_tx_data  <= w_crc_stepped[CRC5_W-1];
                        end else begin
                            r_cnt     <= r_cnt - 1'b1;
                            r_tx_data <= w_shift_nxt[PAYLOAD_W-1];
                        end
                    end
                end
                SHIFT_CRC: begin
                    if (bus.bit_en) begin
                        if (r_cnt == '0) begin
                            r_state    <= DONE;
                            r_tx_data  <= 1'b0;
                            r_tx_valid <= 1'b0;
                            r_done     <= 1'b1;
                            r_crc5_out <= r_crc_hold;
                        end else begin
                            r_cnt     <= r_cnt - 1'b1;
                            r_tx_data <= w_crc[CRC5_W-2] ^ (w_err && (r_cnt == CNT_W'(1)));
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = r_tx_valid;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.crc5_out = r_crc5_out;

endmodule

// File: tb/tb_crc5_tx_gen.sv
// Self-checking bench for crc5_tx_gen: table vectors, random frames with strobe gaps, corner sequences.
module tb_crc5_tx_gen;

    localparam int W = 17;

    typedef struct {
        logic [W-1:0] pl;
        logic [4:0]   exp_crc;
        int           max_gap;
        bit           load_in_done;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    crc5_tx_gen_if #(.PAYLOAD_W(W)) bus ();

    crc5_tx_gen #(.PAYLOAD_W(W)) dut (
        .clk_crc5            (clk),
        .rst_for_new_package (rst_n),
        .bus                 (bus.slave)
    );

    // Reference: remainder of (preset*x^n + msg*x^5) modulo x^5+x^3+1, by long division.
    function automatic logic [4:0] crc_ref(input logic [127:0] msg, input int n);
        logic [127:0] dv;
        dv = (msg << 5) ^ (128'(5'b01001) << n);
        for (int i = n + 4; i >= 5; i--) begin
            if (dv[i]) dv = dv ^ (128'(6'b101001) << (i - 5));
        end
        return dv[4:0];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [W-1:0] pl, input logic [4:0] exp_crc, input int max_gap,
                             input int reload_at, input bit en_with_load, input bit load_in_done,
                             input bit err, input string tag);
        logic [127:0] exp_stream;
        logic [127:0] got;
        int           nbits;
        int           cyc;
        bit           seen_done;
        bit           valid_ok;
        int           g;
        exp_stream = (128'(pl) << 5) | 128'(exp_crc);
        if (err) exp_stream = exp_stream ^ 128'(1);
`ifdef CRC5_ERR_INJECT_EN
        bus.err_inject = err;
`endif
        bus.payload = pl;
        bus.load    = 1'b1;
        bus.bit_en  = en_with_load;
        tick();
        bus.load   = 1'b0;
        bus.bit_en = 1'b0;
        got = '0; nbits = 0; cyc = 0; seen_done = 1'b0; valid_ok = 1'b1;
        while (!seen_done && cyc < 4000) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) begin
                tick();
                cyc++;
                if (bus.done) valid_ok = 1'b0;
            end
            if (nbits == reload_at) begin
                bus.load    = 1'b1;
                bus.payload = '1;
                tick();
                bus.load = 1'b0;
                cyc++;
            end
            if (!bus.tx_valid || !bus.busy) valid_ok = 1'b0;
            got = (got << 1) | 128'(bus.tx_data);
            nbits++;
            bus.bit_en = 1'b1;
            tick();
            bus.bit_en = 1'b0;
            cyc++;
            if (bus.done) seen_done = 1'b1;
        end
        check({tag, " done_seen"}, 128'(seen_done), 128'(1));
        check({tag, " stream"}, got, exp_stream);
        check({tag, " strobes"}, 128'(nbits), 128'(W + 5));
        check({tag, " crc5_out"}, 128'(bus.crc5_out), 128'(exp_crc));
        check({tag, " valid_busy"}, 128'(valid_ok), 128'(1));
        if (err) check({tag, " residue_bad"}, 128'(crc_ref(got, W + 5) != 5'd0), 128'(1));
        else     check({tag, " residue"}, 128'(crc_ref(got, W + 5)), 128'(0));
        bus.load    = load_in_done;
        bus.payload = '1;
        tick();
        bus.load = 1'b0;
        check({tag, " after_done"}, {bus.done, bus.busy, bus.tx_valid}, 128'(0));
        check({tag, " crc_hold"}, 128'(bus.crc5_out), 128'(exp_crc));
    endtask

    vec_t vecs[7];

    initial begin
        logic [W-1:0] rp;
        bit           idle_bad;
        bit           done_bad;
        bus.load    = 1'b0;
        bus.payload = '0;
        bus.bit_en  = 1'b0;
`ifdef CRC5_ERR_INJECT_EN
        bus.err_inject = 1'b0;
`endif
        vecs[0] = '{17'h00000, 5'h07, 0, 1'b0};
        vecs[1] = '{17'h1FFFF, crc_ref(128'(17'h1FFFF), W), 0, 1'b0};
        vecs[2] = '{17'h10000, crc_ref(128'(17'h10000), W), 2, 1'b0};
        vecs[3] = '{17'h00001, crc_ref(128'(17'h00001), W), 0, 1'b1};
        vecs[4] = '{17'h0AAAA, crc_ref(128'(17'h0AAAA), W), 3, 1'b0};
        vecs[5] = '{17'h15555, crc_ref(128'(17'h15555), W), 1, 1'b1};
        vecs[6] = '{17'h12345, crc_ref(128'(17'h12345), W), 7, 1'b0};

        #2 rst_n = 1'b0;
        tick();
        tick();
        check("reset_outputs", {bus.tx_data, bus.tx_valid, bus.busy, bus.done, bus.crc5_out}, 128'(0));
        rst_n = 1'b1;
        tick();

        run_frame(17'h00000, 5'h07, 0, -1, 1'b0, 1'b0, 1'b0, "zero");

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].pl, vecs[i].exp_crc, vecs[i].max_gap, -1, 1'b0,
                      vecs[i].load_in_done, 1'b0, $sformatf("vec%0d", i));
        end

        run_frame(17'h0F0F0, crc_ref(128'(17'h0F0F0), W), 2, 6, 1'b0, 1'b0, 1'b0, "reload_ignored");

        bus.payload = '0;
        bus.load    = 1'b1;
        tick();
        bus.load   = 1'b0;
        bus.bit_en = 1'b1;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        check("midframe_reset", {bus.tx_data, bus.tx_valid, bus.busy, bus.done, bus.crc5_out}, 128'(0));
        tick();
        bus.bit_en = 1'b0;
        rst_n      = 1'b1;
        done_bad   = 1'b0;
        repeat (6) begin
            tick();
            if (bus.done || bus.busy) done_bad = 1'b1;
        end
        check("no_done_after_reset", 128'(done_bad), 128'(0));
        run_frame(17'h00000, 5'h07, 1, -1, 1'b0, 1'b0, 1'b0, "zero_after_reset");

        bus.bit_en = 1'b1;
        idle_bad   = 1'b0;
        repeat (10) begin
            tick();
            if (bus.busy || bus.tx_valid || bus.done) idle_bad = 1'b1;
        end
        check("idle_bit_en_ignored", 128'(idle_bad), 128'(0));
        run_frame(17'h15A5A, crc_ref(128'(17'h15A5A), W), 0, -1, 1'b1, 1'b0, 1'b0, "load_with_bit_en");

        for (int i = 0; i < 200; i++) begin
            rp = W'($urandom);
            run_frame(rp, crc_ref(128'(rp), W), 7, -1, 1'b0, 1'($urandom_range(1, 0)), 1'b0,
                      $sformatf("rand%0d", i));
        end

`ifdef CRC5_ERR_INJECT_EN
        run_frame(17'h00000, 5'h07, 0, -1, 1'b0, 1'b0, 1'b1, "err_inject");
        run_frame(17'h00000, 5'h07, 0, -1, 1'b0, 1'b0, 1'b0, "err_cleared");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/crc5_tx_gen.md
Name: crc5_tx_gen

Overview:
Serial CRC-5 generator/transmitter for EPC Gen2 frames, the transmit-side counterpart of the CRC-5 checker.
- Loads a PAYLOAD_W-bit frame in parallel, default 17 bits (Query).
- Shifts the frame out MSB first, one bit per bit_en strobe, and computes CRC-5 on the fly.
- Then shifts out the 5-bit CRC, MSB first.
- Sits ahead of the PIE/modulator in reader models and the test environment; its output must give a zero residue in the CRC-5 checker.

Parameters:
PAYLOAD_W, 17, payload bits per frame (legal range 1..64).

Ports:
clk_crc5  in  1  bit clock
rst_for_new_package  in  1  async active-low reset
load  in  1  start pulse; captures payload when idle
payload  in  PAYLOAD_W  frame bits; payload[PAYLOAD_W-1] is sent first
bit_en  in  1  per-bit strobe; the current tx_data is consumed on a cycle where this is high
tx_data  out  1  current serial bit
tx_valid  out  1  tx_data meaningful (data or CRC phase)
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the last CRC bit is consumed
crc5_out  out  5  final CRC, held stable from done until the next load

Behaviour:
- Reset: rst_for_new_package is asynchronous, active-low; clock is clk_crc5. While reset is asserted:
  - state = IDLE, CRC register = 5'b01001, bit counter = 0, shift register = 0.
  - tx_data = 0, tx_valid = 0, busy = 0, done = 0, crc5_out = 0.
- Polynomial: x^5+x^3+1, preset 5'b01001. On each data-bit step, with fb = d ^ r[4], the register r[4:0] updates to {r[3], r[2]^fb, r[1], r[0], fb}.
- FSM states and transitions:
  - IDLE -> SHIFT_DATA when load=1. Payload is captured into the shift register, CRC is preset, counter = PAYLOAD_W-1.
  - SHIFT_DATA: tx_data = shift_reg MSB; tx_valid = 1.
    - On bit_en: CRC steps with d = tx_data, shift register shifts left, counter decrements.
    - After the bit at counter 0 is consumed -> SHIFT_CRC, counter = 4.
  - SHIFT_CRC: tx_data = r[4]; tx_valid = 1.
    - On bit_en: r shifts left with zero fill (equivalent to a CRC step with d = r[4], so fb = 0). Counter decrements.
    - After the bit at counter 0 is consumed -> DONE. crc5_out is set to the CRC value latched at the SHIFT_DATA -> SHIFT_CRC transition.
  - DONE: done = 1 for exactly one cycle -> IDLE.
- busy = 1 in SHIFT_DATA, SHIFT_CRC and DONE. tx_valid = 0 in IDLE and DONE.
- Each bit is consumed in the same cycle bit_en is high. The next bit appears on tx_data the following cycle. Back-to-back bit_en every cycle is legal; total frame = PAYLOAD_W+5 strobes.
- Boundary conditions:
  - load while busy: ignored.
  - load and bit_en in the same IDLE cycle: load wins; that bit_en is not consumed.
  - bit_en in IDLE or DONE: ignored.
  - load during the DONE cycle: ignored. A new load is accepted from IDLE, one cycle after done.
  - Reset mid-frame: immediate abort to reset values. No done pulse.
  - PAYLOAD_W = 1: SHIFT_DATA lasts one strobe.

Optional Feature:
CRC5_ERR_INJECT_EN:
- Defined: adds input port err_inject (1 bit), sampled on the load cycle and held for the frame. When set, the last transmitted CRC bit is inverted on tx_data, producing a deliberately failing frame. crc5_out still reports the true CRC.
- Undefined: the port is absent and the CRC is always correct.

Decomposition:
- Package crc5_pkg holds:
  - CRC5_PRESET = 5'b01001 and CRC5_POLY = 5'b01001 (taps x^3, x^0).
  - CRC5_W = 5.
  - State enum {IDLE, SHIFT_DATA, SHIFT_CRC, DONE}.
  - A function crc5_step(r, d) returning the next register value, shared with the checker.
- One natural sub-module, crc5_lfsr: preset/step/shift-out register with inputs preset, step, shift_out, d. Instantiated by the generator; reusable by the checker.

Test Plan:
- Reset then load with payload = 17'h00000, bit_en every cycle -> 17 zero bits, then CRC bits 0,0,1,1,1 on tx_data; crc5_out = 5'h07; done pulses once, 22 strobes after load.
- Loopback: tx_data/bit_en driven into the CRC-5 checker for 200 random payloads with random bit_en gaps (0-7 idle cycles) -> crc5_check_pass = 1 after every frame.
- load asserted again mid-frame with payload = 17'h1FFFF -> ignored; the original frame's bits and CRC are unchanged.
- rst_for_new_package pulsed low after bit 9 -> all outputs return to 0, no done; the next frame with payload = 0 still yields 5'h07.
- bit_en held high in IDLE for 10 cycles, then load and bit_en in the same cycle -> first payload bit is not consumed; it is presented on the cycle after load and consumed on the next strobe.
- With CRC5_ERR_INJECT_EN defined, err_inject = 1 and payload = 0 -> transmitted CRC bits 0,0,1,1,0; checker reports fail; crc5_out = 5'h07.
